imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/CPU_package.sv | 20 ++
 rtl/imem_loader.sv | 111 +++++++++++
 tb/tb_imem_loader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/CPU_package.sv
// rtl/CPU_package.sv - shared CPU widths and the instruction-memory loader state type.
package CPU_package;

  localparam int DATA_WIDTH        = 16;
  localparam int ADDRESS_WIDTH     = 6;
  // Instruction memory depth in words; the largest image a load may carry.
  localparam int ADDRESS_MAX_WIDTH = 64;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN_HI,
    LD_LEN_LO,
    LD_DATA_HI,
    LD_DATA_LO,
    LD_WRITE,
    LD_DONE,
    LD_ERROR
  } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a big-endian length-prefixed word image from a byte stream into instruction memory.
module imem_loader
  import CPU_package::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic                     we_IM,
  output logic [ADDRESS_WIDTH-1:0] address_IM,
  output logic [DATA_WIDTH-1:0]    dataIM,
  output logic                     busy,
  output logic                     load_done,
  output logic                     load_err
);

  localparam logic [15:0] LEN_MAX = 16'(ADDRESS_MAX_WIDTH);

  loader_state_t           state_q, state_d;
  logic [15:0]             len_q, len_d;
  logic [7:0]              hi_q, hi_d;
  // One extra bit so the post-increment count can reach ADDRESS_MAX_WIDTH without wrapping.
  logic [ADDRESS_WIDTH:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [ADDRESS_WIDTH:0]  addr_next;
  logic [15:0]             len_rx;
  logic                    xfer;

  assign xfer       = rx_valid && rx_ready;
  assign addr_next  = addr_q + (ADDRESS_WIDTH+1)'(1);
  assign len_rx     = {len_q[15:8], rx_data};
  assign address_IM = addr_q[ADDRESS_WIDTH-1:0];
  assign dataIM     = data_q;
  assign load_done  = (state_q == LD_DONE);
  assign load_err   = (state_q == LD_ERROR);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    hi_d     = hi_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rx_ready = 1'b0;
    we_IM    = 1'b0;
    busy     = 1'b1;
    case (state_q)
      LD_IDLE, LD_DONE, LD_ERROR: begin
        busy = 1'b0;
        if (start) begin
          state_d = LD_LEN_HI;
          addr_d  = '0;
        end
      end
      LD_LEN_HI: begin
        rx_ready = 1'b1;
        if (xfer) begin
          len_d   = {rx_data, len_q[7:0]};
          state_d = LD_LEN_LO;
        end
      end
      LD_LEN_LO: begin
        rx_ready = 1'b1;
        if (xfer) begin
          len_d = len_rx;
          if (len_rx == 16'd0)        state_d = LD_DONE;
          else if (len_rx > LEN_MAX)  state_d = LD_ERROR;
          else                        state_d = LD_DATA_HI;
        end
      end
      LD_DATA_HI: begin
        rx_ready = 1'b1;
        if (xfer) begin
          hi_d    = rx_data;
          state_d = LD_DATA_LO;
        end
      end
      LD_DATA_LO: begin
        rx_ready = 1'b1;
        if (xfer) begin
          data_d  = {hi_q, rx_data};
          state_d = LD_WRITE;
        end
      end
      LD_WRITE: begin
        we_IM   = 1'b1;
        addr_d  = addr_next;
        state_d = (16'(addr_next) == len_q) ? LD_DONE : LD_DATA_HI;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LD_IDLE;
      len_q   <= '0;
      hi_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a stream-level image model.
module tb_imem_loader;
  import CPU_package::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [7:0]               rx_data;
  logic                     rx_valid;
  logic                     rx_ready;
  logic                     we_IM;
  logic [ADDRESS_WIDTH-1:0] address_IM;
  logic [DATA_WIDTH-1:0]    dataIM;
  logic                     busy;
  logic                     load_done;
  logic                     load_err;

  int total = 0;
  int bad   = 0;
  int wr_count = 0;
  logic we_prev = 1'b0;
  logic [15:0] act_img [0:ADDRESS_MAX_WIDTH-1];
  logic [15:0] exp_img [0:ADDRESS_MAX_WIDTH-1];
  logic [15:0] wsrc    [0:ADDRESS_MAX_WIDTH-1];

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .we_IM(we_IM), .address_IM(address_IM), .dataIM(dataIM),
    .busy(busy), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Memory-side observer: captures every write and flags strobes wider than one cycle.
  always @(negedge clk) begin
    if (we_IM) begin
      wr_count++;
      act_img[address_IM] = dataIM;
      if (we_prev) check("we_width", 32'd2, 32'd1);
    end
    we_prev = we_IM;
  end

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int k;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    rx_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      rx_data = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (k = 0; k < 300 && !rx_ready; k++) @(negedge clk);
    if (!rx_ready) begin
      check("rx_timeout", 32'(rx_ready), 32'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input int n, input int gap, input bit mid_start);
    int w0;
    int limit;
    w0 = wr_count;
    limit = (n > ADDRESS_MAX_WIDTH) ? 0 : n;
    for (int i = 0; i < limit; i++) exp_img[i] = wsrc[i];
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_clr_done", 32'(load_done), 32'd0);
    check("start_clr_err", 32'(load_err), 32'd0);
    send_byte(8'(n >> 8), gap);
    send_byte(8'(n), gap);
    if (n == 0) begin
      check("n0_done", 32'(load_done), 32'd1);
      check("n0_busy", 32'(busy), 32'd0);
    end else if (n > ADDRESS_MAX_WIDTH) begin
      check("big_err", 32'(load_err), 32'd1);
      check("big_done", 32'(load_done), 32'd0);
      rx_valid = 1'b1;
      rx_data  = 8'h5A;
      repeat (4) begin
        check("err_rx_ready", 32'(rx_ready), 32'd0);
        @(negedge clk);
      end
      rx_valid = 1'b0;
      check("err_sticky", 32'(load_err), 32'd1);
    end else begin
      for (int i = 0; i < n; i++) begin
        send_byte(wsrc[i][15:8], gap);
        send_byte(wsrc[i][7:0], gap);
        check("we_latency", 32'(we_IM), 32'd1);
        check("wr_addr", 32'(address_IM), 32'(i));
        check("wr_data", 32'(dataIM), 32'(wsrc[i]));
        if (mid_start && i == 0 && n > 1) begin
          @(negedge clk);
          pulse_start();
          check("mid_start_busy", 32'(busy), 32'd1);
        end
      end
      @(negedge clk);
      check("end_done", 32'(load_done), 32'd1);
      check("end_busy", 32'(busy), 32'd0);
      check("end_rx_ready", 32'(rx_ready), 32'd0);
      for (int i = 0; i < n; i++) check("image", 32'(act_img[i]), 32'(exp_img[i]));
    end
    check("write_count", 32'(wr_count - w0), 32'(limit));
  endtask

  task automatic fill_random();
    for (int i = 0; i < ADDRESS_MAX_WIDTH; i++) wsrc[i] = 16'($urandom);
  endtask

  initial begin
    int w0;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    for (int i = 0; i < ADDRESS_MAX_WIDTH; i++) act_img[i] = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(we_IM), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_addr", 32'(address_IM), 32'd0);
    check("rst_data", 32'(dataIM), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Bytes offered while idle must not be taken.
    rx_valid = 1'b1; rx_data = 8'h77;
    repeat (3) begin
      check("idle_rx_ready", 32'(rx_ready), 32'd0);
      @(negedge clk);
    end
    rx_valid = 1'b0;

    fill_random();
    wsrc[0] = 16'h1234; wsrc[1] = 16'hABCD;
    run_load(2, 0, 1'b0);
    run_load(0, 0, 1'b0);
    run_load(ADDRESS_MAX_WIDTH + 1, 2, 1'b0);
    fill_random();
    run_load(ADDRESS_MAX_WIDTH, 0, 1'b0);
    fill_random();
    run_load(4, 5, 1'b0);
    fill_random();
    run_load(3, 1, 1'b1);

    // Abort after the second word's hi byte.
    fill_random();
    w0 = wr_count;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    send_byte(wsrc[0][15:8], 1);
    send_byte(wsrc[0][7:0], 1);
    send_byte(wsrc[1][15:8], 1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rx_ready", 32'(rx_ready), 32'd0);
    check("abort_we", 32'(we_IM), 32'd0);
    check("abort_addr", 32'(address_IM), 32'd0);
    check("abort_data", 32'(dataIM), 32'd0);
    check("abort_done", 32'(load_done), 32'd0);
    rx_valid = 1'b1; rx_data = wsrc[1][7:0];
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rx_valid = 1'b0;
    check("abort_writes", 32'(wr_count - w0), 32'd1);
    fill_random();
    run_load(4, 2, 1'b0);

    for (int t = 0; t < 6; t++) begin
      fill_random();
      run_load(int'($urandom_range(1, 12)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
